version_report_tx: RTL and testbench

- Sequencer that serializes the build-identification constants from version_pkg into a framed byte stream on a valid/ready byte interface.
- The stream normally feeds the UART TX path, so host tools can read back firmware version and build timestamp.
- Frames are sent on an explicit request pulse or on a free-running periodic tick.
- At most one frame is in flight; further requests coalesce into a single pending flag.

---
 rtl/version_pkg.sv | 15 +
 rtl/version_report_pkg.sv | 59 +++++
 rtl/version_tick_gen.sv | 26 ++
 rtl/version_report_tx.sv | 97 +++++++++
 tb/tb_version_report_tx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/version_pkg.sv
// rtl/version_pkg.sv - build identification constants stamped into the report frame
package version_pkg;

  localparam logic [7:0]  VERSION_MAJOR = 8'h00;
  localparam logic [7:0]  VERSION_MINOR = 8'h00;
  localparam logic [7:0]  VERSION_PATCH = 8'h00;
  localparam logic [7:0]  VERSION_BUILD = 8'h36;
  localparam logic [15:0] BUILD_YEAR    = 16'h2025;
  localparam logic [7:0]  BUILD_MONTH   = 8'h11;
  localparam logic [7:0]  BUILD_DAY     = 8'h05;
  localparam logic [7:0]  BUILD_HOUR    = 8'h18;
  localparam logic [7:0]  BUILD_MINUTE  = 8'h54;
  localparam logic [7:0]  BUILD_SECOND  = 8'h41;

endpackage

// File: rtl/version_report_pkg.sv
// rtl/version_report_pkg.sv - frame layout, state type and frame builder for the version report
package version_report_pkg;
  import version_pkg::*;

  localparam int C_FRAME_LEN = 14;

  localparam logic [3:0] C_IDX_SYNC0  = 4'd0;
  localparam logic [3:0] C_IDX_SYNC1  = 4'd1;
  localparam logic [3:0] C_IDX_MAJOR  = 4'd2;
  localparam logic [3:0] C_IDX_MINOR  = 4'd3;
  localparam logic [3:0] C_IDX_PATCH  = 4'd4;
  localparam logic [3:0] C_IDX_BUILD  = 4'd5;
  localparam logic [3:0] C_IDX_YEAR_H = 4'd6;
  localparam logic [3:0] C_IDX_YEAR_L = 4'd7;
  localparam logic [3:0] C_IDX_MONTH  = 4'd8;
  localparam logic [3:0] C_IDX_DAY    = 4'd9;
  localparam logic [3:0] C_IDX_HOUR   = 4'd10;
  localparam logic [3:0] C_IDX_MINUTE = 4'd11;
  localparam logic [3:0] C_IDX_SECOND = 4'd12;
  localparam logic [3:0] C_IDX_CHK    = 4'd13;

  localparam logic [7:0] C_SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] C_SYNC1_DEFAULT = 8'h5A;

  typedef logic [C_FRAME_LEN-1:0][7:0] frame_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Checksum covers the payload only (MAJOR..SECOND), never the sync bytes.
  function automatic frame_t build_frame(input logic [7:0] sync0, input logic [7:0] sync1);
    frame_t     f;
    logic [7:0] chk;
    f               = '0;
    f[C_IDX_SYNC0]  = sync0;
    f[C_IDX_SYNC1]  = sync1;
    f[C_IDX_MAJOR]  = VERSION_MAJOR;
    f[C_IDX_MINOR]  = VERSION_MINOR;
    f[C_IDX_PATCH]  = VERSION_PATCH;
    f[C_IDX_BUILD]  = VERSION_BUILD;
    f[C_IDX_YEAR_H] = BUILD_YEAR[15:8];
    f[C_IDX_YEAR_L] = BUILD_YEAR[7:0];
    f[C_IDX_MONTH]  = BUILD_MONTH;
    f[C_IDX_DAY]    = BUILD_DAY;
    f[C_IDX_HOUR]   = BUILD_HOUR;
    f[C_IDX_MINUTE] = BUILD_MINUTE;
    f[C_IDX_SECOND] = BUILD_SECOND;
    chk = 8'h00;
    for (int i = int'(C_IDX_MAJOR); i <= int'(C_IDX_SECOND); i++) begin
      chk = chk ^ f[i];
    end
    f[C_IDX_CHK] = chk;
    return f;
  endfunction

endpackage

// File: rtl/version_tick_gen.sv
// rtl/version_tick_gen.sv - free-running period counter emitting a one-cycle tick at wrap
module version_tick_gen #(
  parameter logic [31:0] PERIOD_CYCLES = 32'd100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam logic [31:0] C_LAST = (PERIOD_CYCLES == 32'd0) ? 32'd0 : PERIOD_CYCLES - 32'd1;

  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else if (PERIOD_CYCLES == 32'd0 || cnt_q == C_LAST) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign tick_o = (PERIOD_CYCLES != 32'd0) && (cnt_q == C_LAST);

endmodule

// File: rtl/version_report_tx.sv
// rtl/version_report_tx.sv - serializes the build identification frame onto a byte stream
module version_report_tx
  import version_report_pkg::*;
#(
  parameter logic [31:0] PERIOD_CYCLES = 32'd100_000_000,
  parameter logic [7:0]  SYNC0         = C_SYNC0_DEFAULT,
  parameter logic [7:0]  SYNC1         = C_SYNC1_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger_i,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        busy_o,
  output logic [15:0] frame_count_o
);

  localparam frame_t C_FRAME = build_frame(SYNC0, SYNC1);

  state_t     state_q;
  logic [3:0] idx_q;
  logic [3:0] idx_nxt;
  logic       pending_q;
  logic       tick;
  logic       req;

  version_tick_gen #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  assign req     = trigger_i | tick;
  assign idx_nxt = idx_q + 4'd1;
  assign busy_o  = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= 4'd0;
      pending_q     <= 1'b0;
      m_tvalid      <= 1'b0;
      m_tlast       <= 1'b0;
      m_tdata       <= 8'h00;
      frame_count_o <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          // A request coinciding with a stale pending flag still yields one frame.
          if (req || pending_q) begin
            state_q   <= SEND;
            idx_q     <= 4'd0;
            pending_q <= 1'b0;
            m_tvalid  <= 1'b1;
            m_tdata   <= C_FRAME[0];
            m_tlast   <= 1'b0;
          end
        end
        SEND: begin
          if (req) begin
            pending_q <= 1'b1;
          end
          if (m_tready) begin
            if (idx_q == C_IDX_CHK) begin
              state_q  <= DONE;
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
              m_tdata  <= 8'h00;
            end else begin
              idx_q   <= idx_nxt;
              m_tdata <= C_FRAME[idx_nxt];
              m_tlast <= (idx_nxt == C_IDX_CHK);
            end
          end
        end
        DONE: begin
          if (req) begin
            pending_q <= 1'b1;
          end
          frame_count_o <= frame_count_o + 16'd1;
          state_q       <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          m_tvalid <= 1'b0;
          m_tlast  <= 1'b0;
          m_tdata  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_version_report_tx.sv
// tb/tb_version_report_tx.sv - randomized bench for version_report_tx against a frame-level model
module tb_version_report_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic        rdy;
  logic [7:0]  tdata_w [2];
  logic        tvalid_w[2];
  logic        tlast_w [2];
  logic        busy_w  [2];
  logic [15:0] count_w [2];

  always #5 clk = ~clk;

  version_report_tx #(.PERIOD_CYCLES(32'd0)) u_dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .trigger_i     (trig),
    .m_tdata       (tdata_w[0]),
    .m_tvalid      (tvalid_w[0]),
    .m_tready      (rdy),
    .m_tlast       (tlast_w[0]),
    .busy_o        (busy_w[0]),
    .frame_count_o (count_w[0])
  );

  version_report_tx #(.PERIOD_CYCLES(32'd20)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .trigger_i     (trig),
    .m_tdata       (tdata_w[1]),
    .m_tvalid      (tvalid_w[1]),
    .m_tready      (rdy),
    .m_tlast       (tlast_w[1]),
    .busy_o        (busy_w[1]),
    .frame_count_o (count_w[1])
  );

  logic [7:0] ref_frame[14] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h36, 8'h20,
                                8'h25, 8'h11, 8'h05, 8'h18, 8'h54, 8'h41, 8'h2A};
  int unsigned period[2] = '{0, 20};

  // Model position: -1 idle, 0..13 byte being offered, 14 the closing gap cycle.
  int m_pos [2];
  bit m_pend[2];
  int m_cnt [2];
  int m_cyc [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pos[d] = -1; m_pend[d] = 1'b0; m_cnt[d] = 0; m_cyc[d] = 0;
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      bit ev;
      ev = (m_pos[d] >= 0) && (m_pos[d] <= 13);
      check($sformatf("d%0d.tvalid", d), tvalid_w[d], ev);
      check($sformatf("d%0d.tlast", d), tlast_w[d], (m_pos[d] == 13));
      check($sformatf("d%0d.busy", d), busy_w[d], (m_pos[d] >= 0));
      check($sformatf("d%0d.count", d), count_w[d], m_cnt[d]);
      if (ev) check($sformatf("d%0d.tdata[%0d]", d, m_pos[d]), tdata_w[d], ref_frame[m_pos[d]]);
    end
  endtask

  task automatic step();
    for (int d = 0; d < 2; d++) begin
      bit tk;
      bit req;
      tk = 1'b0;
      if (period[d] != 0) tk = ((m_cyc[d] % period[d]) == period[d] - 1);
      req = trig | tk;
      if (m_pos[d] < 0) begin
        if (req || m_pend[d]) begin
          m_pos[d] = 0; m_pend[d] = 1'b0;
        end
      end else if (m_pos[d] <= 13) begin
        if (req) m_pend[d] = 1'b1;
        if (rdy) m_pos[d]++;
      end else begin
        if (req) m_pend[d] = 1'b1;
        m_cnt[d] = (m_cnt[d] + 1) & 16'hFFFF;
        m_pos[d] = -1;
      end
      m_cyc[d]++;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse();
    trig = 1'b1; step(); trig = 1'b0;
  endtask

  task automatic wait_idle0();
    for (int i = 0; i < 100 && !(m_pos[0] < 0 && !m_pend[0]); i++) step();
  endtask

  int base;

  initial begin
    rst_n = 1'b0; trig = 1'b0; rdy = 1'b0;
    model_reset();
    #12;
    check("rst.tvalid", tvalid_w[0], 0);
    check("rst.tdata", tdata_w[0], 0);
    check("rst.busy", busy_w[0], 0);
    check("rst.count", count_w[0], 0);
    rst_n = 1'b1;

    // Single trigger, free-flowing sink.
    rdy = 1'b1;
    run(2);
    pulse();
    check("lat.byte0", tdata_w[0], 8'hA5);
    run(20);
    check("single.count", count_w[0], 1);

    // Backpressure with a long stall at the year-high byte.
    wait_idle0();
    pulse();
    for (int i = 0; i < 200 && m_pos[0] != 6; i++) begin
      rdy = $urandom_range(0, 1); step();
    end
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall.tdata", tdata_w[0], 8'h20);
    end
    for (int i = 0; i < 200 && m_pos[0] >= 0; i++) begin
      rdy = $urandom_range(0, 1); step();
    end
    check("bp.count", count_w[0], 2);

    // Several requests during a frame coalesce into one extra frame.
    rdy = 1'b1;
    wait_idle0();
    base = m_cnt[0];
    pulse();
    run(2); pulse(); run(2); pulse(); run(2); pulse();
    run(40);
    check("coalesce.count", count_w[0], (base + 2) & 16'hFFFF);

    // Trigger landing on the periodic tick while the periodic instance idles.
    for (int i = 0; i < 100 && !(m_pos[1] < 0 && !m_pend[1] && (m_cyc[1] % 20) == 19); i++) step();
    base = m_cnt[1];
    pulse();
    run(18);
    check("tick+trig.count", count_w[1], (base + 1) & 16'hFFFF);

    // Asynchronous reset in the middle of a frame.
    wait_idle0();
    pulse();
    for (int i = 0; i < 50 && m_pos[0] != 7; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.tvalid0", tvalid_w[0], 0);
    check("arst.tvalid1", tvalid_w[1], 0);
    check("arst.count0", count_w[0], 0);
    check("arst.busy0", busy_w[0], 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulse();
    check("post_rst.byte0", tdata_w[0], 8'hA5);
    run(20);

    // Frame counter wrap from all-ones.
    wait_idle0();
    force u_dut0.frame_count_o = 16'hFFFF;
    #1;
    release u_dut0.frame_count_o;
    m_cnt[0] = 16'hFFFF;
    check("force.count", count_w[0], 16'hFFFF);
    pulse();
    run(20);
    check("wrap.count", count_w[0], 0);

    // Random requests and sink readiness.
    for (int i = 0; i < 3000; i++) begin
      trig = ($urandom_range(0, 15) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      step();
    end
    trig = 1'b0; rdy = 1'b1;
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
